// File: rtl/router_pkt_ctrl.sv
// router_pkt_ctrl: packet-sequencing FSM for the 1x3 router ingress path.
// Decodes the header address, waits for the destination FIFO, then walks the
// register stage through header load, payload load, full-stall, parity load
// and parity check. The strobes and busy are a pure decode of the state.
// Optional feature macro: PKT_LEN_CHECK_EN (payload length check -> len_err).
//
// Handshake: the source presents a byte with pkt_vld=1 and holds it while
// busy=1; a byte is consumed on any rising clk edge where busy=0.
module router_pkt_ctrl #(
    parameter int NUM_DEST = 3,
    parameter int LEN_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pkt_vld,
    input  logic [7:0]          data_in,
    input  logic                fifo_full,
    input  logic [NUM_DEST-1:0] fifo_empty,
    input  logic [NUM_DEST-1:0] soft_reset,
    input  logic                parity_done,
    input  logic                low_pkt_vld,
    output logic [1:0]          dest_addr,
    output logic                detect_add,
    output logic                lfd_state,
    output logic                ld_state,
    output logic                laf_state,
    output logic                full_state,
    output logic                rst_int_reg,
    output logic                write_enb_reg,
    output logic                busy,
    output logic                len_err,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_DECODE_ADDRESS     = 3'd0,
        S_WAIT_TILL_EMPTY    = 3'd1,
        S_LOAD_FIRST_DATA    = 3'd2,
        S_LOAD_DATA          = 3'd3,
        S_FIFO_FULL_STATE    = 3'd4,
        S_LOAD_AFTER_FULL    = 3'd5,
        S_LOAD_PARITY        = 3'd6,
        S_CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_dest_addr;

    logic [1:0] w_hdr_addr;
    logic       w_addr_ok;
    logic       w_hdr_empty;
    logic       w_sel_empty;
    logic       w_sel_soft;
    logic       w_hdr_take;
    logic       w_soft_abort;

    assign w_hdr_addr   = data_in[1:0];
    assign w_addr_ok    = (int'(w_hdr_addr) < NUM_DEST);
    assign w_hdr_take   = (r_state == S_DECODE_ADDRESS) && pkt_vld && w_addr_ok;
    assign w_soft_abort = (r_state != S_DECODE_ADDRESS) && w_sel_soft;

    // Select per-destination flags by header address and by latched address.
    always_comb begin
        w_hdr_empty = 1'b0;
        w_sel_empty = 1'b0;
        w_sel_soft  = 1'b0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (w_hdr_addr == 2'(i)) w_hdr_empty = fifo_empty[i];
            if (r_dest_addr == 2'(i)) begin
                w_sel_empty = fifo_empty[i];
                w_sel_soft  = soft_reset[i];
            end
        end
    end

    // State register and destination address latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_DECODE_ADDRESS;
            r_dest_addr <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (w_hdr_take) r_dest_addr <= w_hdr_addr;
        end
    end

    // Next-state logic; a soft reset of the selected destination overrides all.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_DECODE_ADDRESS: begin
                if (w_hdr_take) begin
                    w_next_state = w_hdr_empty ? S_LOAD_FIRST_DATA : S_WAIT_TILL_EMPTY;
                end
            end
            S_WAIT_TILL_EMPTY: begin
                if (w_sel_empty) w_next_state = S_LOAD_FIRST_DATA;
            end
            S_LOAD_FIRST_DATA: w_next_state = S_LOAD_DATA;
            S_LOAD_DATA: begin
                if (fifo_full)     w_next_state = S_FIFO_FULL_STATE;
                else if (!pkt_vld) w_next_state = S_LOAD_PARITY;
            end
            S_FIFO_FULL_STATE: begin
                if (!fifo_full) w_next_state = S_LOAD_AFTER_FULL;
            end
            S_LOAD_AFTER_FULL: begin
                if (parity_done)      w_next_state = S_DECODE_ADDRESS;
                else if (low_pkt_vld) w_next_state = S_LOAD_PARITY;
                else                  w_next_state = S_LOAD_DATA;
            end
            S_LOAD_PARITY: w_next_state = S_CHECK_PARITY_ERROR;
            S_CHECK_PARITY_ERROR: begin
                w_next_state = fifo_full ? S_FIFO_FULL_STATE : S_DECODE_ADDRESS;
            end
            default: w_next_state = S_DECODE_ADDRESS;
        endcase
        if (w_soft_abort) w_next_state = S_DECODE_ADDRESS;
    end

    // Moore strobes decoded straight from the state register.
    always_comb begin
        detect_add    = (r_state == S_DECODE_ADDRESS);
        lfd_state     = (r_state == S_LOAD_FIRST_DATA);
        ld_state      = (r_state == S_LOAD_DATA);
        laf_state     = (r_state == S_LOAD_AFTER_FULL);
        full_state    = (r_state == S_FIFO_FULL_STATE);
        rst_int_reg   = (r_state == S_CHECK_PARITY_ERROR);
        write_enb_reg = (r_state == S_LOAD_DATA) || (r_state == S_LOAD_PARITY) ||
                        (r_state == S_LOAD_AFTER_FULL);
        busy          = !((r_state == S_DECODE_ADDRESS) || (r_state == S_LOAD_DATA));
    end

    assign dest_addr = r_dest_addr;
    assign state_dbg = r_state;

`ifdef PKT_LEN_CHECK_EN
    logic [LEN_W-1:0] r_hdr_len;
    logic [LEN_W-1:0] r_cnt;

    // Header length latch and saturating payload byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_len <= '0;
            r_cnt     <= '0;
        end else if (w_hdr_take) begin
            r_hdr_len <= data_in[7:2];
            r_cnt     <= '0;
        end else if (w_soft_abort) begin
            r_cnt <= '0;
        end else if ((r_state == S_LOAD_DATA) && pkt_vld && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign len_err = (r_state == S_CHECK_PARITY_ERROR) && (r_cnt != r_hdr_len);
`else
    // Length field is ignored when the check is compiled out.
    logic [LEN_W-1:0] w_unused_len;
    assign w_unused_len = data_in[7:2];
    assign len_err      = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// tb_router_pkt_ctrl: directed bench for router_pkt_ctrl. The driver sets
// inputs each cycle and queues the expected Moore outputs; a monitor on the
// falling edge pops and compares. Honours PKT_LEN_CHECK_EN for len_err.
module tb_router_pkt_ctrl;

    typedef enum int {B_DEC, B_WTE, B_LFD, B_LD, B_FULL, B_LAF, B_LP, B_CPE} bst_t;

`ifdef PKT_LEN_CHECK_EN
    localparam bit LEN_ON = 1'b1;
`else
    localparam bit LEN_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       pkt_vld;
    logic [7:0] data_in;
    logic       fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_vld;
    logic [1:0] dest_addr;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy, len_err;
    logic [2:0] state_dbg;

    logic [10:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          we_cnt = 0;
    logic        we_win = 1'b0;
    logic [10:0] mon_vec;

    router_pkt_ctrl dut (
        .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_pkt_vld(low_pkt_vld),
        .dest_addr(dest_addr), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy),
        .len_err(len_err), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mon_vec = {dest_addr, detect_add, lfd_state, ld_state, laf_state,
                      full_state, rst_int_reg, write_enb_reg, busy, len_err};

    // Expected output vector for a given state, address and length error.
    function automatic logic [10:0] ev(input bst_t s, input logic [1:0] da, input logic le);
        logic we, bz;
        we = (s == B_LD) || (s == B_LP) || (s == B_LAF);
        bz = !((s == B_DEC) || (s == B_LD));
        return {da, (s == B_DEC), (s == B_LFD), (s == B_LD), (s == B_LAF),
                (s == B_FULL), (s == B_CPE), we, bz, le};
    endfunction

    function automatic logic lx(input logic v);
        return v & LEN_ON;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Driver: queue expectation for the current cycle, then advance one clock.
    task automatic step(input bst_t s, input logic [1:0] da, input logic le, input string nm);
        exp_q.push_back(ev(s, da, le));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, {5'd0, mon_vec}, {5'd0, e});
        end
        if (we_win) we_cnt += int'(write_enb_reg);
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        rst = 1'b1; pkt_vld = 1'b0; data_in = 8'h00; fifo_full = 1'b0;
        fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {5'd0, mon_vec}, {5'd0, ev(B_DEC, 2'd0, 1'b0)});
        rst = 1'b0;

        // Basic packet: header 0x0D (len 3, addr 1), 3 payload, parity
        we_win = 1'b1;
        pkt_vld = 1'b1; data_in = 8'h0D;
        step(B_DEC, 2'd0, 1'b0, "t2_hdr");
        data_in = 8'h41;
        step(B_LFD, 2'd1, 1'b0, "t2_lfd");
        step(B_LD, 2'd1, 1'b0, "t2_ld1");
        step(B_LD, 2'd1, 1'b0, "t2_ld2");
        step(B_LD, 2'd1, 1'b0, "t2_ld3");
        pkt_vld = 1'b0; data_in = 8'h5A;
        step(B_LD, 2'd1, 1'b0, "t2_ld_par");
        step(B_LP, 2'd1, 1'b0, "t2_lp");
        step(B_CPE, 2'd1, lx(1'b0), "t2_cpe");
        we_win = 1'b0;
        chk("t2_we_cycles", 16'(we_cnt), 16'd5);
        step(B_DEC, 2'd1, 1'b0, "t2_idle");

        // Wait for empty FIFO (addr 2), then a full-stall mid payload
        pkt_vld = 1'b1; data_in = 8'h02; fifo_empty = 3'b011;
        step(B_DEC, 2'd1, 1'b0, "t3_hdr");
        for (int i = 0; i < 4; i++) step(B_WTE, 2'd2, 1'b0, "t3_wait");
        fifo_empty = 3'b111;
        step(B_WTE, 2'd2, 1'b0, "t3_wait_rel");
        step(B_LFD, 2'd2, 1'b0, "t4_lfd");
        step(B_LD, 2'd2, 1'b0, "t4_ld1");
        fifo_full = 1'b1;
        step(B_LD, 2'd2, 1'b0, "t4_ld2");
        step(B_FULL, 2'd2, 1'b0, "t4_full1");
        step(B_FULL, 2'd2, 1'b0, "t4_full2");
        fifo_full = 1'b0;
        step(B_FULL, 2'd2, 1'b0, "t4_full3");
        step(B_LAF, 2'd2, 1'b0, "t4_laf");
        pkt_vld = 1'b0;
        step(B_LD, 2'd2, 1'b0, "t4_ld_par");
        step(B_LP, 2'd2, 1'b0, "t4_lp");
        step(B_CPE, 2'd2, lx(1'b1), "t4_cpe");
        step(B_DEC, 2'd2, 1'b0, "t4_idle");

        // Addr 0: full beats !pkt_vld, LAF->LP, CPE->FULL, LAF->DEC
        pkt_vld = 1'b1; data_in = 8'h00;
        step(B_DEC, 2'd2, 1'b0, "t7_hdr");
        step(B_LFD, 2'd0, 1'b0, "t7_lfd");
        pkt_vld = 1'b0; fifo_full = 1'b1;
        step(B_LD, 2'd0, 1'b0, "t7_ld_full_wins");
        fifo_full = 1'b0;
        step(B_FULL, 2'd0, 1'b0, "t7_full");
        low_pkt_vld = 1'b1;
        step(B_LAF, 2'd0, 1'b0, "t7_laf_low");
        low_pkt_vld = 1'b0;
        step(B_LP, 2'd0, 1'b0, "t7_lp");
        fifo_full = 1'b1;
        step(B_CPE, 2'd0, lx(1'b0), "t7_cpe_full");
        fifo_full = 1'b0;
        step(B_FULL, 2'd0, 1'b0, "t7_full2");
        parity_done = 1'b1;
        step(B_LAF, 2'd0, 1'b0, "t7_laf_done");
        parity_done = 1'b0;
        step(B_DEC, 2'd0, 1'b0, "t7_idle");

        // Invalid header address 3 is dropped
        pkt_vld = 1'b1; data_in = 8'h07;
        step(B_DEC, 2'd0, 1'b0, "inv_hdr");
        pkt_vld = 1'b0;
        step(B_DEC, 2'd0, 1'b0, "inv_after");

        // Soft reset: other destination ignored, selected one aborts
        pkt_vld = 1'b1; data_in = 8'h05;
        step(B_DEC, 2'd0, 1'b0, "t5_hdr");
        step(B_LFD, 2'd1, 1'b0, "t5_lfd");
        soft_reset = 3'b001;
        step(B_LD, 2'd1, 1'b0, "t5_sr_other");
        soft_reset = 3'b010;
        step(B_LD, 2'd1, 1'b0, "t5_sr_sel");
        pkt_vld = 1'b0;
        step(B_DEC, 2'd1, 1'b0, "t5_sr_in_dec");
        soft_reset = 3'b000;
        step(B_DEC, 2'd1, 1'b0, "t5_idle");

        // Length check: header len 4, then 3 and 4 payload bytes
        for (int n = 3; n <= 4; n++) begin
            pkt_vld = 1'b1; data_in = 8'h11;
            step(B_DEC, 2'd1, 1'b0, "t6_hdr");
            step(B_LFD, 2'd1, 1'b0, "t6_lfd");
            for (int i = 0; i < n; i++) step(B_LD, 2'd1, 1'b0, "t6_ld");
            pkt_vld = 1'b0;
            step(B_LD, 2'd1, 1'b0, "t6_ld_par");
            step(B_LP, 2'd1, 1'b0, "t6_lp");
            step(B_CPE, 2'd1, lx(n != 4), "t6_cpe");
            step(B_DEC, 2'd1, 1'b0, "t6_idle");
        end

        // Async reset mid LOAD_DATA (addr 2)
        pkt_vld = 1'b1; data_in = 8'h0E;
        step(B_DEC, 2'd1, 1'b0, "t1_hdr");
        step(B_LFD, 2'd2, 1'b0, "t1_lfd");
        step(B_LD, 2'd2, 1'b0, "t1_ld");
        rst = 1'b1;
        #1;
        chk("t1_detect_add", {15'd0, detect_add}, 16'd1);
        chk("t1_busy", {15'd0, busy}, 16'd0);
        chk("t1_ld_state", {15'd0, ld_state}, 16'd0);
        chk("t1_dest_addr", {14'd0, dest_addr}, 16'd0);
        pkt_vld = 1'b0;
        step(B_DEC, 2'd0, 1'b0, "t1_rst_hold");
        rst = 1'b0;
        step(B_DEC, 2'd0, 1'b0, "t1_after");

        repeat (2) @(negedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
